// File: rtl/mod_reduction_arbiter.sv
// Round-robin share of one iterative modular reducer; >=3 cycles request-to-response, watchdog-bounded wait.
// Backpressure: one job in flight; RESP holds until rsp_ready, and req_ready stays low everywhere but IDLE.
module mod_reduction_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = 1024,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*2*WIDTH-1:0]   req_a,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       red_start,
    output logic [2*WIDTH-1:0]         red_a,
    input  logic                       red_done,
    input  logic [WIDTH-1:0]           red_r,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_r,
    output logic                       rsp_err,
    output logic                       timeout,
    output logic                       busy
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

    state_t                              state;
    logic [ID_W-1:0]                     last;
    logic [ID_W-1:0]                     gidx;
    logic [ID_W-1:0]                     idx;
    logic [N_REQ-1:0]                    grant;
    logic                                found;
    logic [CNT_W-1:0]                    cnt;
    logic [N_REQ-1:0][2*WIDTH-1:0]       a_arr;

    assign a_arr = req_a;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    assign req_ready = grant & {N_REQ{(state == S_IDLE) && !reset}};
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            last      <= ID_W'(N_REQ - 1);
            red_start <= 1'b0;
            red_a     <= '0;
            rsp_id    <= '0;
            rsp_r     <= '0;
            rsp_err   <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= '0;
        end else begin
            red_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        red_a     <= a_arr[gidx];
                        rsp_id    <= gidx;
                        last      <= gidx;
                        red_start <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                // A done still high from the previous job is ignored here.
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (red_done) begin
                        rsp_r   <= red_r;
                        rsp_err <= 1'b0;
                        state   <= S_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_r   <= '0;
                        rsp_err <= 1'b1;
                        timeout <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_reduction_arbiter.sv
// Directed bench for mod_reduction_arbiter: round-robin order, backpressure, watchdog, stale done, async reset.
module tb_mod_reduction_arbiter;
    localparam int N_REQ   = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 2;

    logic                       clk;
    logic                       reset;
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*2*WIDTH-1:0]   req_a;
    logic [N_REQ-1:0]           req_ready;
    logic                       red_start;
    logic [2*WIDTH-1:0]         red_a;
    logic                       red_done;
    logic [WIDTH-1:0]           red_r;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [WIDTH-1:0]           rsp_r;
    logic                       rsp_err;
    logic                       timeout;
    logic                       busy;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Operands per requester and their remainders mod 37, worked out by hand.
    logic [31:0] op  [4] = '{32'd186, 32'd40, 32'd100, 32'd80};
    logic [15:0] exr [4] = '{16'd1, 16'd3, 16'd26, 16'd6};

    mod_reduction_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
        .red_start(red_start), .red_a(red_a), .red_done(red_done), .red_r(red_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_err(rsp_err), .timeout(timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One full job with rsp_ready high; the reducer model answers red_a mod 37 on the first WAIT cycle.
    task automatic run_job(input int eid, input string tag);
        logic [3:0] onehot;
        onehot = 4'b0001 << eid;
        #1;
        chk({tag, "_grant"}, req_ready, onehot);
        tick();
        chk({tag, "_load"}, {red_start, busy, req_ready, red_a}, {1'b1, 1'b1, 4'b0000, op[eid]});
        tick();
        chk({tag, "_wait"}, {red_start, rsp_valid, busy}, 3'b001);
        red_done = 1'b1;
        red_r    = 16'(red_a % 32'd37);
        tick();
        red_done = 1'b0;
        chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_id, rsp_r}, {1'b1, 1'b0, 2'(eid), exr[eid]});
        tick();
        chk({tag, "_idle"}, {rsp_valid, busy}, 2'b00);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_a     = {op[3], op[2], op[1], op[0]};
        red_done  = 1'b0;
        red_r     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs",
            {red_start, red_a, rsp_valid, rsp_id, rsp_r, rsp_err, timeout, busy, req_ready}, 64'd0);
        reset = 1'b0;

        // Contention: all valid from reset
        run_job(0, "rr0");
        run_job(1, "rr1");
        run_job(2, "rr2");
        run_job(3, "rr3");
        run_job(0, "rr4");

        // Fairness after skip
        req_valid = 4'b0010;
        run_job(1, "fair1");
        req_valid = 4'b1001;
        run_job(3, "fair3");
        run_job(0, "fair0");

        // Single job: requester 2, operand 100, p=37
        req_valid = 4'b0100;
        run_job(2, "single");

        // Backpressure
        req_valid = 4'b0001;
        #1;
        chk("bp_grant", req_ready, 4'b0001);
        tick();
        req_valid = 4'b1111;
        tick();
        red_done = 1'b1;
        red_r    = 16'd1;
        tick();
        red_done  = 1'b0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk("bp_hold", {rsp_valid, rsp_id, rsp_r, req_ready, busy},
                {1'b1, 2'd0, 16'd1, 4'b0000, 1'b1});
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release", {rsp_valid, busy, req_ready}, {1'b0, 1'b0, 4'b0010});
        req_valid = 4'b0000;

        // Watchdog: no done ever
        req_valid = 4'b0100;
        #1;
        chk("wd_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        repeat (8) tick();
        chk("wd_early", {rsp_valid, timeout}, 2'b00);
        tick();
        chk("wd_expire", {rsp_valid, rsp_err, rsp_id, rsp_r, timeout},
            {1'b1, 1'b1, 2'd2, 16'd0, 1'b1});
        tick();
        chk("wd_idle", {rsp_valid, busy}, 2'b00);
        req_valid = 4'b0001;
        run_job(0, "post_wd");
        chk("timeout_sticky", timeout, 1'b1);

        // Stale done held through LOAD
        req_valid = 4'b0010;
        #1;
        chk("stale_grant", req_ready, 4'b0010);
        red_done = 1'b1;
        red_r    = 16'd3;
        tick();
        req_valid = 4'b0000;
        tick();
        chk("stale_load", {rsp_valid, busy}, 2'b01);
        tick();
        red_done = 1'b0;
        chk("stale_wait", {rsp_valid, rsp_err, rsp_id, rsp_r}, {1'b1, 1'b0, 2'd1, 16'd3});
        tick();
        chk("stale_idle", {rsp_valid, busy}, 2'b00);

        // Reset mid-WAIT
        req_valid = 4'b1000;
        #1;
        chk("rst_grant", req_ready, 4'b1000);
        tick();
        req_valid = 4'b1111;
        tick();
        tick();
        chk("rst_pre", {busy, rsp_id, rsp_valid}, {1'b1, 2'd3, 1'b0});
        reset = 1'b1;
        #1;
        chk("rst_async",
            {red_start, red_a, rsp_valid, rsp_id, rsp_r, rsp_err, timeout, busy, req_ready}, 64'd0);
        tick();
        reset = 1'b0;
        run_job(0, "post_rst");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/mod_reduction_arbiter.md
# mod_reduction_arbiter

Round-robin scheduler that shares one iterative modular-reduction unit among `N_REQ` requesters in the MSM datapath. It accepts a double-width operand from one requester at a time and pulses the reducer's load/start. It waits for the reducer's done flag, with a watchdog on that wait, and returns the remainder tagged with the requester index over a valid/ready response channel.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 128: remainder width; operands are `2*WIDTH`.
- `TIMEOUT`, 1024: maximum WAIT cycles before the job is abandoned, ≥2.
- `ID_W`, `$clog2(N_REQ)`: tag width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`  per-requester operand valid.
- `req_a`  in  `N_REQ*2*WIDTH`  operands; requester i at bits `[i*2*WIDTH +: 2*WIDTH]`.
- `req_ready`  out  `N_REQ`  one-hot accept, combinational; transfer occurs when `req_valid[i] & req_ready[i]`.
- `red_start`  out  1  one-cycle pulse; reducer loads `red_a`.
- `red_a`  out  `2*WIDTH`  registered operand to the reducer.
- `red_done`  in  1  reducer result valid (level).
- `red_r`  in  `WIDTH`  reducer remainder.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  `ID_W`  index of the requester served.
- `rsp_r`  out  `WIDTH`  remainder; 0 when `rsp_err`.
- `rsp_err`  out  1  job abandoned by watchdog.
- `timeout`  out  1  sticky; set on any watchdog expiry.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE: `req_ready` is asserted for the first i with `req_valid[i]`, searching from `last+1` and wrapping modulo `N_REQ`. `req_ready` is 0 when no request is valid. On accept, latch `req_a` slice into `red_a` and i into `rsp_id`, set `last`=i, then go to LOAD.
  - LOAD: `red_start`=1 for exactly this cycle. Clear the watchdog counter, then go to WAIT. `red_done` is ignored in LOAD, since a stale done from the previous job must not complete the new one.
  - WAIT: if `red_done`, latch `red_r` into `rsp_r`, set `rsp_err`=0 and go to RESP. Otherwise, if counter == `TIMEOUT-1`, set `rsp_r`=0, `rsp_err`=1 and `timeout`=1, then go to RESP. Otherwise increment the counter. `red_done` has priority over expiry in the same cycle.
  - RESP: `rsp_valid`=1. `rsp_id`, `rsp_r` and `rsp_err` stay stable until `rsp_ready`, then go to IDLE.
- `req_ready` is 0 outside IDLE. Only one operand is in flight; there is no queueing.
- Requests that are not granted are not latched. A requester may drop `req_valid` before it is granted.
- Watchdog counter width is `$clog2(TIMEOUT)`; it never wraps.
- `timeout` is cleared only by `reset`.

## Timing
- Reset values, applied asynchronously:
  - State IDLE; `last`=`N_REQ-1`, so requester 0 has first priority.
  - All outputs 0: `red_start`, `red_a`, `rsp_valid`, `rsp_id`, `rsp_r`, `rsp_err`, `timeout`, `busy`, `req_ready`.
- Accept at edge T: `red_start` is high during cycle T+1, and WAIT begins at T+2.
- `red_done` sampled at edge T+k (k≥2): `rsp_valid` is high from cycle T+k+1.
- Minimum request-to-response latency is 3 cycles. Minimum issue interval is 4 cycles with `rsp_ready` held high.
- Watchdog: `red_done` never arrives → `rsp_valid` with `rsp_err`=1 rises exactly `TIMEOUT+2` cycles after the accept edge.
- `rsp_ready` held low: the block stalls in RESP indefinitely, and all requesters see `req_ready`=0.
- Reset asserted in any state aborts the job immediately. `red_start` drops without completing its pulse, and the pending response is discarded.

## Test plan
- Single job: requester 2 sends `req_a`=100 with the reducer model for p=37 → `red_start` pulse with `red_a`=100, then `rsp_valid` with `rsp_id`=2, `rsp_r`=26, `rsp_err`=0.
- Contention: all four `req_valid` held high from reset → grants in order 0,1,2,3,0. `req_ready` is one-hot and only in IDLE.
- Fairness after skip: requester 1 is served, then requesters 0 and 3 are both valid → 3 is granted before 0.
- Backpressure: `rsp_ready` low for 20 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_r` stay stable and no new grant occurs; release → return to IDLE next cycle.
- Watchdog: `TIMEOUT`=8, `red_done` never asserts → `rsp_err`=1, `rsp_r`=0 and `timeout`=1 exactly 10 cycles after accept. `timeout` stays 1 after the next good job.
- Stale done / reset: `red_done` held high through LOAD → not accepted until WAIT. Asserting `reset` mid-WAIT → all outputs 0 at once, and requester 0 is granted first afterward.
